// File: rtl/audio_pkg.sv
// audio_pkg: shared note divider table, sequencer state type and entry field widths
//   NOTE_W   : width of the note code field of a playlist entry
//   DIV_W    : native width of the divider counts in NOTE_DIV
//   note_div : maps note codes 0..7 (Do5..Do6) to 50 MHz divider counts
package audio_pkg;
    localparam int NOTE_W = 4;
    localparam int DIV_W  = 20;
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_PLAY,
        S_GAP,
        S_ADVANCE,
        S_FINISH
    } seq_state_t;
    function automatic logic [DIV_W-1:0] note_div(input logic [2:0] code);
        case (code)
            3'd0:    note_div = 20'd95602;
            3'd1:    note_div = 20'd85179;
            3'd2:    note_div = 20'd75873;
            3'd3:    note_div = 20'd71633;
            3'd4:    note_div = 20'd63776;
            3'd5:    note_div = 20'd56818;
            3'd6:    note_div = 20'd50607;
            default: note_div = 20'd47801;
        endcase
    endfunction
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides in_clk into one-cycle duration ticks every TICK_DIV enabled cycles
//   in_clk  : system clock
//   reset_n : asynchronous active-low reset
//   clear   : restart the count from zero (has priority over enable)
//   enable  : advance the count
//   tick    : high on the last cycle of each TICK_DIV-cycle period
module tick_prescaler #(
    parameter int TICK_DIV = 50000
) (
    input  logic in_clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    logic [CW-1:0] r_cnt;
    always_ff @(posedge in_clk or negedge reset_n) begin
        if (!reset_n)
            r_cnt <= '0;
        else if (clear)
            r_cnt <= '0;
        else if (enable)
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
    // Not gated by clear: the final tick of a window lands on the cycle the state changes.
    assign tick = enable && (r_cnt == LAST);
endmodule

// File: rtl/tone_sequencer.sv
// tone_sequencer: steps through a stored note playlist and drives the audio divider
//   in_clk/reset_n        : clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data : playlist write port {note[3:0], dur}, ignored while busy
//   len/loop              : entry count (latched on start), repeat flag (read at last ADVANCE)
//   start/stop            : start pulse, abort pulse (stop wins over start)
//   busy/done/cur_index   : status, natural-completion pulse, entry being played
//   freq_counter/on_off   : divider configuration
module tone_sequencer
    import audio_pkg::*;
#(
    parameter int N         = 20,
    parameter int DEPTH     = 16,
    parameter int DUR_W     = 16,
    parameter int TICK_DIV  = 50000,
    parameter int GAP_TICKS = 0
) (
    input  logic                       in_clk,
    input  logic                       reset_n,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [NOTE_W+DUR_W-1:0]    wr_data,
    input  logic [$clog2(DEPTH):0]     len,
    input  logic                       loop,
    input  logic                       start,
    input  logic                       stop,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH)-1:0]   cur_index,
    output logic [N-1:0]               freq_counter,
    output logic                       on_off
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = NOTE_W + DUR_W;
    logic [EW-1:0]     r_mem [DEPTH];
    seq_state_t        r_state, w_next;
    logic [AW-1:0]     r_index;
    logic [AW:0]       r_len;
    logic [DUR_W-1:0]  r_left;
    logic [N-1:0]      r_freq;
    logic              r_rest;
    logic              r_zdone;
    logic [NOTE_W-1:0] w_note;
    logic [DUR_W-1:0]  w_dur;
    logic              w_start, w_tick, w_last_tick, w_last_idx;
    always_ff @(posedge in_clk) begin
        if (wr_en && !busy)
            r_mem[wr_addr] <= wr_data;
    end
    // Read during FETCH; the entry is captured into r_rest/r_left/r_freq at the end of it.
    // A write accepted together with start commits before FETCH, so playback sees it.
    assign {w_note, w_dur} = r_mem[r_index];
    assign w_start     = start && !stop && (r_state == S_IDLE);
    assign w_last_tick = w_tick && (r_left == DUR_W'(1));
    assign w_last_idx  = ({1'b0, r_index} == r_len - 1'b1);
    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .in_clk  (in_clk),
        .reset_n (reset_n),
        .clear   (r_state != w_next),
        .enable  (r_state == S_PLAY || r_state == S_GAP),
        .tick    (w_tick)
    );
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = (w_start && len != '0) ? S_FETCH : S_IDLE;
            S_FETCH:   w_next = (w_dur == '0) ? S_FINISH : S_PLAY;
            S_PLAY:    w_next = w_last_tick ? ((GAP_TICKS != 0) ? S_GAP : S_ADVANCE) : S_PLAY;
            S_GAP:     w_next = w_last_tick ? S_ADVANCE : S_GAP;
            S_ADVANCE: w_next = (w_last_idx && !loop) ? S_FINISH : S_FETCH;
            default:   w_next = S_IDLE;
        endcase
        if (stop && r_state != S_IDLE)
            w_next = S_IDLE;
    end
    always_ff @(posedge in_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_index <= '0;
            r_len   <= '0;
            r_left  <= '0;
            r_freq  <= '0;
            r_rest  <= 1'b0;
            r_zdone <= 1'b0;
        end else begin
            r_state <= w_next;
            r_zdone <= w_start && (len == '0);
            if (w_start) begin
                r_len   <= len;
                r_index <= '0;
            end else if (r_state == S_ADVANCE && w_next == S_FETCH) begin
                r_index <= w_last_idx ? '0 : r_index + 1'b1;
            end
            if (r_state == S_FETCH && w_next == S_PLAY) begin
                r_left <= w_dur;
                r_rest <= w_note[NOTE_W-1];
                // A rest leaves the divider count untouched.
                if (!w_note[NOTE_W-1])
                    r_freq <= N'(note_div(w_note[2:0]));
            end else if (r_state == S_PLAY && w_next == S_GAP) begin
                r_left <= DUR_W'(GAP_TICKS);
            end else if (w_tick) begin
                r_left <= r_left - 1'b1;
            end
        end
    end
    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_FINISH) || r_zdone;
    assign on_off       = (r_state == S_PLAY) && !r_rest;
    assign freq_counter = r_freq;
    assign cur_index    = r_index;
endmodule
